cd_manchester_tx: RTL

- Channel coder stage directly downstream of the slave data packet controller.
- Accepts bytes on a level-qualified q/q_rdy interface and serialises each one as a Manchester-coded frame onto the HSI line.
- Frame: start, 8 data LSB-first, odd parity, stop.
- Drives cd_busy, which the upstream controller uses as its per-byte pacing and counting strobe.
- Inserts a mandatory line-idle gap after each message end.

---
 rtl/hsi_cd_pkg.sv | 27 ++
 rtl/cd_manchester_tx_timer.sv | 35 +++
 rtl/cd_manchester_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hsi_cd_pkg.sv
// Shared definitions for the HSI channel coder: FSM states, Manchester polarity
// and frame geometry.
package hsi_cd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } cd_state_t;

    // Line level during the first half of a '1'; a '0' is the mirror image.
    localparam logic MANCH_ONE_FIRST_HALF = 1'b0;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Line level for one half of a Manchester-coded bit.
    function automatic logic manch_level(input logic bit_val, input logic second_half);
        logic first_half;
        first_half = bit_val ? MANCH_ONE_FIRST_HALF : ~MANCH_ONE_FIRST_HALF;
        return second_half ? ~first_half : first_half;
    endfunction

endpackage

// File: rtl/cd_manchester_tx_timer.sv
// Half-bit timer: divides clk into Manchester half-bits and full bit times.
module cd_halfbit_timer #(
    parameter int HALF_BIT_CLKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half_tick,
    output logic bit_tick,
    output logic half
);

    localparam int CNT_W = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;

    logic [CNT_W-1:0] half_cnt;

    assign half_tick = (half_cnt == CNT_W'(HALF_BIT_CLKS - 1));
    assign bit_tick  = half_tick & half;

    // Count clk cycles within a half-bit; flip the half flag at each wrap.
    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every flop samples pre-edge values and
        // simulation order between always blocks cannot change the result.
        if (rst || clear) begin
            half_cnt <= '0;
            half     <= 1'b0;
        end else if (half_tick) begin
            half_cnt <= '0;
            half     <= ~half;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cd_manchester_tx.sv
// Manchester frame transmitter: accepts a byte from the packet controller and
// sends start, 8 data bits LSB-first, odd parity and stop, then enforces an
// idle gap on the line after each message end.
module cd_manchester_tx
    import hsi_cd_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 4,
    parameter int GAP_BITS      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] q,
    input  logic       q_rdy,
    input  logic       msg_end,
    output logic       cd_busy,
    output logic       cd_gap,
    output logic       line_out,
    output logic       line_oe,
    output logic       frame_done
);

    localparam int GAP_CLKS = GAP_BITS * 2 * HALF_BIT_CLKS;
    localparam int GAP_W    = $clog2(GAP_CLKS);

    cd_state_t        state, state_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             parity, parity_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic             msg_end_d;
    logic             accept;
    logic             half_tick, bit_tick, half, half_nxt;
    logic             line_bit;
    logic             in_frame_nxt;

    cd_halfbit_timer #(
        .HALF_BIT_CLKS(HALF_BIT_CLKS)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .half_tick(half_tick),
        .bit_tick (bit_tick),
        .half     (half)
    );

    // Half flag as it will be after this edge, so outputs can be registered
    // without adding a cycle of latency.
    assign half_nxt = accept ? 1'b0 : (half ^ half_tick);

    assign in_frame_nxt = (state_nxt == ST_START) || (state_nxt == ST_DATA) ||
                          (state_nxt == ST_PARITY) || (state_nxt == ST_STOP);

    // Next-state, datapath update and the bit to be driven in the next cycle.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        shreg_nxt   = shreg;
        parity_nxt  = parity;
        bit_idx_nxt = bit_idx;
        gap_cnt_nxt = gap_cnt;
        accept      = 1'b0;
        line_bit    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // A new message end wins over a waiting byte.
                if (msg_end && !msg_end_d) begin
                    state_nxt   = ST_GAP;
                    gap_cnt_nxt = '0;
                end else if (q_rdy) begin
                    accept      = 1'b1;
                    shreg_nxt   = q;
                    parity_nxt  = ~^q;
                    bit_idx_nxt = '0;
                    state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shreg_nxt   = {1'b0, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (bit_tick) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (bit_tick) state_nxt = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CLKS - 1)) begin
                    state_nxt   = ST_IDLE;
                    gap_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        unique case (state_nxt)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shreg_nxt[0];
            ST_PARITY: line_bit = parity_nxt;
            ST_STOP:   line_bit = 1'b1;
            default:   line_bit = 1'b0;
        endcase
    end

    // State, datapath and registered outputs.  The cycle after STOP shows
    // cd_busy low and may already accept the next byte, giving exactly one
    // low cycle between back-to-back frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            parity     <= 1'b0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            msg_end_d  <= 1'b0;
            cd_busy    <= 1'b0;
            cd_gap     <= 1'b0;
            line_out   <= 1'b0;
            line_oe    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            parity     <= parity_nxt;
            bit_idx    <= bit_idx_nxt;
            gap_cnt    <= gap_cnt_nxt;
            // Tracks msg_end as seen while idle or in the gap; a rise during a
            // frame stays pending, and a level held through the gap is ignored.
            msg_end_d  <= msg_end && (msg_end_d || (state == ST_IDLE) || (state == ST_GAP));
            cd_busy    <= in_frame_nxt;
            line_oe    <= in_frame_nxt;
            line_out   <= in_frame_nxt && manch_level(line_bit, half_nxt);
            cd_gap     <= (state_nxt == ST_GAP);
            frame_done <= (state == ST_STOP) && (state_nxt == ST_IDLE);
        end
    end

endmodule
